// File: rtl/debug_halt_ctrl_if.sv
// Debug halt handshake bundle: halt/resume/step requests in, pipeline control and status out.
interface debug_halt_ctrl_if;
    logic       halt_req;
    logic       ext_halt_req;
    logic       resume;
    logic       step;
    logic       pc_stall;
    logic       fetch_flush;
    logic       halted;
    logic       halt_cause;
    logic [1:0] state_o;

    modport master (
        output halt_req, ext_halt_req, resume, step,
        input  pc_stall, fetch_flush, halted, halt_cause, state_o
    );

    modport slave (
        input  halt_req, ext_halt_req, resume, step,
        output pc_stall, fetch_flush, halted, halt_cause, state_o
    );
endinterface

// File: rtl/debug_halt_ctrl.sv
// Debug halt controller: stalls fetch, drains the pipeline, then parks the core in HALTED.
// Single-step support (STEP state) is compiled only when DEBUG_STEP_EN is defined.
module debug_halt_ctrl #(
    parameter int DRAIN_CYCLES = 3
) (
    input logic             clk,
    input logic             rst,
    debug_halt_ctrl_if.slave dbg
);

    // A drain length of 0 is treated as 1 so the counter always has a valid reload.
    localparam int         EFF_DRAIN = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
    localparam logic [3:0] DRAIN_LOAD = 4'(EFF_DRAIN - 1);

`ifdef DEBUG_STEP_EN
    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2, STEP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;
    logic step_unused;
    assign step_unused = dbg.step;
`endif

    state_t     state_q;
    state_t     state_d;
    logic [3:0] cnt_q;
    logic       cause_q;
    logic       any_req;
    logic       stall;
    logic       halted;

    assign any_req = dbg.halt_req | dbg.ext_halt_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Cause is latched only on entry to DRAIN; ebreak wins when both requests coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= 4'd0;
            cause_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (any_req) begin
                        cnt_q   <= DRAIN_LOAD;
                        cause_q <= dbg.ext_halt_req & ~dbg.halt_req;
                    end
                end
                DRAIN: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
`ifdef DEBUG_STEP_EN
                STEP: begin
                    cnt_q <= DRAIN_LOAD;
                end
`endif
                default: begin
                    cnt_q <= cnt_q;
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (any_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_q == 4'd0) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                if (dbg.resume) begin
                    state_d = RUN;
                end
`ifdef DEBUG_STEP_EN
                else if (dbg.step) begin
                    state_d = STEP;
                end
`endif
            end
`ifdef DEBUG_STEP_EN
            STEP: begin
                state_d = DRAIN;
            end
`endif
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Reset gating keeps a level request from stalling fetch while rst is held.
    always_comb begin
        stall  = 1'b0;
        halted = 1'b0;
        case (state_q)
            RUN:     stall = any_req;
            DRAIN:   stall = 1'b1;
            HALTED: begin
                stall  = 1'b1;
                halted = 1'b1;
            end
            default: stall = 1'b0;
        endcase
        stall = stall & ~rst;
    end

    assign dbg.pc_stall    = stall;
    assign dbg.fetch_flush = stall;
    assign dbg.halted      = halted;
    assign dbg.halt_cause  = cause_q;
    assign dbg.state_o     = state_q;

endmodule

// File: tb/tb_debug_halt_ctrl.sv
// Scoreboard bench for debug_halt_ctrl: directed per-cycle vectors queue expectations, a negedge monitor checks them.
module tb_debug_halt_ctrl;

    logic clk;
    logic rst;

    debug_halt_ctrl_if dbg();

    debug_halt_ctrl #(.DRAIN_CYCLES(3)) dut (
        .clk (clk),
        .rst (rst),
        .dbg (dbg)
    );

    typedef struct {
        string      name;
        logic [5:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;
    localparam logic [1:0] S_STEP   = 2'd3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs {state_o, pc_stall, fetch_flush, halted, halt_cause} and compares against the expected bundle.
    task automatic checkOutput(input string name, input logic [5:0] expv);
        logic [5:0] act;
        act = {dbg.state_o, dbg.pc_stall, dbg.fetch_flush, dbg.halted, dbg.halt_cause};
        checks++;
        if (act === expv) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got state/stall/flush/halted/cause=%b required %b", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput(e.name, e.val);
        end
    end

    // One clock of stimulus, plus the outputs expected during that same cycle.
    task automatic applyStimulus(input logic hr, input logic ehr, input logic res, input logic stp,
                                 input logic [1:0] st, input logic stall, input logic hlt,
                                 input logic cause, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        dbg.halt_req     = hr;
        dbg.ext_halt_req = ehr;
        dbg.resume       = res;
        dbg.step         = stp;
        e.name = name;
        e.val  = {st, stall, stall, hlt, cause};
        exp_q.push_back(e);
    endtask

    initial begin
        rst              = 1'b1;
        dbg.halt_req     = 1'b0;
        dbg.ext_halt_req = 1'b0;
        dbg.resume       = 1'b0;
        dbg.step         = 1'b0;
        #2;
        checkOutput("reset_state", 6'b00_0000);
        #1;
        dbg.halt_req = 1'b1;
        #1;
        checkOutput("reset_masks_stall", 6'b00_0000);
        dbg.halt_req = 1'b0;
        #8;
        rst = 1'b0;

        applyStimulus(0,0,0,0, S_RUN,    0,0,0, "idle_run");
        applyStimulus(1,0,0,0, S_RUN,    1,0,0, "ebreak_stall_same_cycle");
        applyStimulus(0,0,0,0, S_DRAIN,  1,0,0, "drain1");
        applyStimulus(0,0,0,0, S_DRAIN,  1,0,0, "drain2");
        applyStimulus(0,0,0,0, S_DRAIN,  1,0,0, "drain3");
        applyStimulus(1,0,0,0, S_HALTED, 1,1,0, "halted_ebreak");
        applyStimulus(0,1,0,0, S_HALTED, 1,1,0, "halted_hold_cause");
        applyStimulus(0,0,1,0, S_HALTED, 1,1,0, "resume_pulse");
        applyStimulus(0,0,0,0, S_RUN,    0,0,0, "run_after_resume");
        applyStimulus(0,0,1,1, S_RUN,    0,0,0, "run_ignores_resume_step");

        applyStimulus(1,1,0,0, S_RUN,    1,0,0, "both_req_stall");
        applyStimulus(0,0,1,0, S_DRAIN,  1,0,0, "drain_resume_ignored");
        applyStimulus(0,1,0,1, S_DRAIN,  1,0,0, "drain_req_ignored");
        applyStimulus(0,0,1,0, S_DRAIN,  1,0,0, "drain_last");
        applyStimulus(0,0,0,0, S_HALTED, 1,1,0, "halted_both_cause0");
        applyStimulus(0,0,1,0, S_HALTED, 1,1,0, "resume2");

        applyStimulus(0,1,0,0, S_RUN,    1,0,0, "ext_stall");
        applyStimulus(0,1,0,0, S_DRAIN,  1,0,1, "ext_drain1");
        applyStimulus(0,1,0,0, S_DRAIN,  1,0,1, "ext_drain2");
        applyStimulus(0,1,0,0, S_DRAIN,  1,0,1, "ext_drain3");
        applyStimulus(0,1,1,1, S_HALTED, 1,1,1, "resume_and_step");
        applyStimulus(0,1,0,0, S_RUN,    1,0,1, "rehalt_level_ext");
        applyStimulus(0,0,0,0, S_DRAIN,  1,0,1, "rehalt_drain1");
        applyStimulus(0,0,0,0, S_DRAIN,  1,0,1, "rehalt_drain2");
        applyStimulus(0,0,0,0, S_DRAIN,  1,0,1, "rehalt_drain3");
        applyStimulus(0,0,0,1, S_HALTED, 1,1,1, "step_pulse");
`ifdef DEBUG_STEP_EN
        applyStimulus(0,0,0,0, S_STEP,   0,0,1, "step_fetch");
        applyStimulus(0,0,0,0, S_DRAIN,  1,0,1, "step_drain1");
        applyStimulus(0,0,0,0, S_DRAIN,  1,0,1, "step_drain2");
        applyStimulus(0,0,0,0, S_DRAIN,  1,0,1, "step_drain3");
        applyStimulus(0,0,1,0, S_HALTED, 1,1,1, "halted_after_step");
`else
        applyStimulus(0,0,0,0, S_HALTED, 1,1,1, "step_ignored1");
        applyStimulus(0,0,1,0, S_HALTED, 1,1,1, "step_ignored2");
`endif
        applyStimulus(0,0,0,0, S_RUN,    0,0,1, "run_keeps_cause");

        applyStimulus(0,1,0,0, S_RUN,    1,0,1, "pre_reset_stall");
        applyStimulus(0,0,0,0, S_DRAIN,  1,0,1, "pre_reset_drain_cnt2");
        applyStimulus(0,0,0,0, S_DRAIN,  1,0,1, "pre_reset_drain_cnt1");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_mid_drain", 6'b00_0000);
        @(negedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(0,0,0,0, S_RUN,    0,0,0, "post_reset1");
        applyStimulus(0,0,0,0, S_RUN,    0,0,0, "post_reset2");
        applyStimulus(0,0,0,0, S_RUN,    0,0,0, "post_reset3");
        applyStimulus(0,0,0,0, S_RUN,    0,0,0, "post_reset4");
        applyStimulus(0,0,0,0, S_RUN,    0,0,0, "post_reset5");

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            passes++;
        end else begin
            $display("[TB] FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
